// File: rtl/dl_ctrl_pkg.sv
// Shared types and helpers for the data-load controller: FSM states,
// address-split widths and MSB-first word placement within a memory line.
package dl_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_DELIVER = 2'd3
    } dl_state_e;

    function automatic int unsigned off_width(input int unsigned words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int unsigned laddr_width(input int unsigned addr_w,
                                                input int unsigned words_per_line);
        return addr_w - $clog2(words_per_line);
    endfunction

    // Word offset 0 occupies the MSBs of the line.
    function automatic int unsigned word_lsb(input int unsigned off,
                                             input int unsigned word_w,
                                             input int unsigned words_per_line);
        return (words_per_line - 1 - off) * word_w;
    endfunction

endpackage

// File: rtl/dl_rr_arbiter.sv
// Rotating-priority find-first: grants the first requester at or after ptr,
// wrapping modulo NUM_CORES. Purely combinational.
module dl_rr_arbiter
    import dl_ctrl_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_CORES-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            idx = IDX_W'((32'(ptr) + k) % NUM_CORES);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/dl_ctrl_arb.sv
// Arbitrating data-load controller: one line read per distinct line address,
// round-robin between cores, broadcast of the returned line to all matching cores.
module dl_ctrl_arb
    import dl_ctrl_pkg::*;
#(
    parameter int  NUM_CORES      = 4,
    parameter int  WORD_W         = 16,
    parameter int  WORDS_PER_LINE = 4,
    parameter int  ADDR_W         = 16,
    parameter int  MEM_LAT        = 1,
    localparam int OFF_W          = off_width(WORDS_PER_LINE),
    localparam int LADDR_W        = laddr_width(ADDR_W, WORDS_PER_LINE),
    localparam int LINE_W         = WORD_W * WORDS_PER_LINE
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        mr,
    input  logic [NUM_CORES*ADDR_W-1:0] maddr,
    output logic                        mem_read,
    output logic [LADDR_W-1:0]          mem_addr,
    input  logic [LINE_W-1:0]           mem_data,
    output logic [NUM_CORES*WORD_W-1:0] dout,
    output logic [NUM_CORES-1:0]        dvalid,
    output logic                        busy
);

    localparam int IDX_W = $clog2(NUM_CORES);
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    dl_state_e                   state;
    logic [IDX_W-1:0]            rr_ptr;
    logic [IDX_W-1:0]            lead_q;
    logic [IDX_W-1:0]            grant_idx;
    logic [NUM_CORES-1:0]        grant;
    logic [NUM_CORES-1:0]        match;
    logic [NUM_CORES-1:0]        serve_mask;
    logic [LADDR_W-1:0]          lead_line;
    logic [LADDR_W-1:0]          laddr_q;
    logic [OFF_W-1:0]            off_q [NUM_CORES];
    logic [CNT_W-1:0]            cnt;
    logic [NUM_CORES*WORD_W-1:0] dout_q;
    logic [NUM_CORES-1:0]        dvalid_q;

    dl_rr_arbiter #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_arb (
        .req       (mr),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        lead_line = maddr[int'(grant_idx)*ADDR_W + OFF_W +: LADDR_W];
        match     = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            match[i] = mr[i] && (maddr[i*ADDR_W + OFF_W +: LADDR_W] == lead_line);
        end
        match = match | grant;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            lead_q     <= '0;
            laddr_q    <= '0;
            serve_mask <= '0;
            cnt        <= '0;
            dout_q     <= '0;
            dvalid_q   <= '0;
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                off_q[i] <= '0;
            end
        end else begin
            dvalid_q <= '0;
            case (state)
                S_IDLE: begin
                    if (|mr) begin
                        lead_q     <= grant_idx;
                        laddr_q    <= lead_line;
                        serve_mask <= match;
                        for (int unsigned i = 0; i < NUM_CORES; i++) begin
                            off_q[i] <= maddr[i*ADDR_W +: OFF_W];
                        end
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= CNT_W'(MEM_LAT);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // The returned line is split straight into dout so the words
                    // and their valid pulse appear together in DELIVER.
                    if (cnt == CNT_W'(1)) begin
                        for (int unsigned i = 0; i < NUM_CORES; i++) begin
                            if (serve_mask[i]) begin
                                dout_q[i*WORD_W +: WORD_W] <=
                                    mem_data[word_lsb(32'(off_q[i]), WORD_W, WORDS_PER_LINE) +: WORD_W];
                            end
                        end
                        dvalid_q <= serve_mask;
                        state    <= S_DELIVER;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DELIVER: begin
                    rr_ptr <= (int'(lead_q) == NUM_CORES - 1) ? '0 : lead_q + IDX_W'(1);
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem_read = (state == S_ISSUE);
    assign mem_addr = laddr_q;
    assign dout     = dout_q;
    assign dvalid   = dvalid_q;
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_dl_ctrl_arb.sv
// Directed bench for dl_ctrl_arb: default build plus a MEM_LAT=3 build,
// each backed by a line-memory response model.
module tb_dl_ctrl_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  mr, mr3;
    logic [63:0] maddr, maddr3;
    logic        mem_read, mem_read3;
    logic [13:0] mem_addr, mem_addr3;
    logic [63:0] mem_data, mem_data3;
    logic [63:0] dout, dout3;
    logic [3:0]  dvalid, dvalid3;
    logic        busy, busy3;
    logic [13:0] last_addr, last_addr3;

    int n_vec = 0;
    int n_err = 0;

    dl_ctrl_arb u_dut (
        .clk(clk), .rst_n(rst_n), .mr(mr), .maddr(maddr),
        .mem_read(mem_read), .mem_addr(mem_addr), .mem_data(mem_data),
        .dout(dout), .dvalid(dvalid), .busy(busy)
    );

    dl_ctrl_arb #(.MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .mr(mr3), .maddr(maddr3),
        .mem_read(mem_read3), .mem_addr(mem_addr3), .mem_data(mem_data3),
        .dout(dout3), .dvalid(dvalid3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line 0 holds {1,5,9,13}; line L holds L + 0x100*k at offset k.
    function automatic logic [63:0] line_of(input logic [13:0] la);
        logic [15:0] b;
        b = 16'(la);
        if (la == 14'd0) return {16'd1, 16'd5, 16'd9, 16'd13};
        return {b, b + 16'h0100, b + 16'h0200, b + 16'h0300};
    endfunction

    always @(posedge clk) if (mem_read)  last_addr  <= mem_addr;
    always @(posedge clk) if (mem_read3) last_addr3 <= mem_addr3;
    assign mem_data  = line_of(last_addr);
    assign mem_data3 = line_of(last_addr3);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int core, input logic [15:0] a);
        maddr[core*16 +: 16] = a;
    endtask

    // ISSUE, WAIT and DELIVER cycles of one default-build transaction.
    task automatic run_xact(input string tag, input logic [13:0] eaddr,
                            input logic [3:0] evalid, input logic [63:0] edout);
        tick;
        chk({tag, " issue mem_read"}, 64'(mem_read), 64'd1);
        chk({tag, " issue mem_addr"}, 64'(mem_addr), 64'(eaddr));
        chk({tag, " issue busy"}, 64'(busy), 64'd1);
        tick;
        chk({tag, " wait mem_read"}, 64'(mem_read), 64'd0);
        chk({tag, " wait dvalid"}, 64'(dvalid), 64'd0);
        tick;
        chk({tag, " dvalid"}, 64'(dvalid), 64'(evalid));
        chk({tag, " dout"}, dout, edout);
    endtask

    logic [63:0] exp_dout;
    logic [15:0] exp3 [4];

    initial begin
        rst_n  = 1'b0;
        mr     = '0;
        mr3    = '0;
        maddr  = '0;
        maddr3 = '0;
        tick;
        tick;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset mem_read", 64'(mem_read), 64'd0);
        chk("reset mem_addr", 64'(mem_addr), 64'd0);
        chk("reset dout", dout, 64'd0);
        chk("reset dvalid", 64'(dvalid), 64'd0);
        chk("reset busy3", 64'(busy3), 64'd0);
        rst_n = 1'b1;
        tick;

        // Four distinct lines: served in pointer order, four cycles apart.
        set_addr(0, 16'd4);
        set_addr(1, 16'd8);
        set_addr(2, 16'd12);
        set_addr(3, 16'd16);
        mr = 4'b1111;
        exp_dout = '0;
        for (int i = 0; i < 4; i++) begin
            exp_dout[i*16 +: 16] = 16'(i + 1);
            run_xact("distinct", 14'(i + 1), 4'(1 << i), exp_dout);
            mr[i] = 1'b0;
            tick;
            chk("distinct idle dvalid", 64'(dvalid), 64'd0);
            chk("distinct idle busy", 64'(busy), 64'd0);
        end
        chk("distinct held dout", dout, 64'h0004_0003_0002_0001);

        // All cores on line 0, two offsets: one read, broadcast.
        set_addr(0, 16'd0);
        set_addr(1, 16'd0);
        set_addr(2, 16'd1);
        set_addr(3, 16'd1);
        mr = 4'b1111;
        run_xact("shared", 14'd0, 4'b1111, 64'h0005_0005_0001_0001);
        mr = '0;
        tick;
        chk("shared idle dvalid", 64'(dvalid), 64'd0);
        chk("shared dout held", dout, 64'h0005_0005_0001_0001);

        // Core 1 alone (line 8, offset 2) moves the pointer to 2.
        set_addr(1, 16'd34);
        mr = 4'b0010;
        run_xact("core1", 14'd8, 4'b0010, 64'h0005_0005_0208_0001);
        mr = '0;
        tick;

        // Fairness: core 3 wins over core 0 with the pointer at 2.
        set_addr(0, 16'd20);
        set_addr(3, 16'd24);
        mr = 4'b1001;
        run_xact("fair c3", 14'd6, 4'b1000, 64'h0006_0005_0208_0001);
        mr[3] = 1'b0;
        tick;
        run_xact("fair c0", 14'd5, 4'b0001, 64'h0006_0005_0208_0005);
        mr = '0;
        tick;

        // Late joiner on the same line raised during WAIT.
        set_addr(0, 16'd28);
        mr = 4'b0001;
        tick;
        chk("late issue mem_addr", 64'(mem_addr), 64'd7);
        tick;
        set_addr(2, 16'd29);
        mr[2] = 1'b1;
        tick;
        chk("late first dvalid", 64'(dvalid), 64'b0001);
        chk("late first dout", dout, 64'h0006_0005_0208_0007);
        mr[0] = 1'b0;
        tick;
        run_xact("late second", 14'd7, 4'b0100, 64'h0006_0107_0208_0007);
        mr = '0;
        tick;

        // Reset during WAIT drops the transaction and rewinds the pointer.
        set_addr(1, 16'd12);
        mr = 4'b0010;
        tick;
        chk("rst issue mem_addr", 64'(mem_addr), 64'd3);
        tick;
        rst_n = 1'b0;
        tick;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst mem_read", 64'(mem_read), 64'd0);
        chk("rst dvalid", 64'(dvalid), 64'd0);
        chk("rst dout", dout, 64'd0);
        chk("rst mem_addr", 64'(mem_addr), 64'd0);
        rst_n = 1'b1;
        set_addr(3, 16'd36);
        mr = 4'b1010;
        run_xact("post-rst c1", 14'd3, 4'b0010, 64'h0000_0000_0003_0000);
        mr[1] = 1'b0;
        tick;
        run_xact("post-rst c3", 14'd9, 4'b1000, 64'h0009_0000_0003_0000);
        mr = '0;
        tick;

        // MEM_LAT=3 build: dvalid five cycles after the decision.
        exp3[0] = 16'h0009;
        exp3[1] = 16'h0109;
        exp3[2] = 16'h0209;
        exp3[3] = 16'h0309;
        for (int off = 0; off < 4; off++) begin
            maddr3[15:0] = 16'(36 + off);
            mr3 = 4'b0001;
            tick;
            chk("lat3 mem_read", 64'(mem_read3), 64'd1);
            chk("lat3 mem_addr", 64'(mem_addr3), 64'd9);
            tick;
            chk("lat3 mem_read second", 64'(mem_read3), 64'd0);
            tick;
            tick;
            chk("lat3 early dvalid", 64'(dvalid3), 64'd0);
            tick;
            chk("lat3 dvalid", 64'(dvalid3), 64'b0001);
            chk("lat3 dout", 64'(dout3[15:0]), 64'(exp3[off]));
            mr3 = '0;
            tick;
            chk("lat3 idle busy", 64'(busy3), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dl_ctrl_arb.md
# dl_ctrl_arb

Parametrised, arbitrating data-load controller between NUM_CORES cores and one shared line-wide read port of data memory. It collects per-core word reads, issues one memory read per distinct line in round-robin order, and broadcasts each returned line to every core pending on that line. Each core receives its word by offset, with a one-cycle valid pulse. It sits between the core load ports and data memory in the multicore matrix datapath.

## Interface
- NUM_CORES, 4, number of requesting cores (≥2)
- WORD_W, 16, core word width
- WORDS_PER_LINE, 4, words per memory line (power of 2); LINE_W = WORD_W*WORDS_PER_LINE
- ADDR_W, 16, core word-address width; OFF_W = log2(WORDS_PER_LINE), LADDR_W = ADDR_W-OFF_W
- MEM_LAT, 1, memory read latency in cycles (≥1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- mr  in  NUM_CORES  per-core read request, level, held until served
- maddr  in  NUM_CORES*ADDR_W  per-core word address; core i at [i*ADDR_W +: ADDR_W]
- mem_read  out  1  memory read strobe, one cycle per transaction
- mem_addr  out  LADDR_W  line address (maddr[ADDR_W-1:OFF_W])
- mem_data  in  LINE_W  returned line; word offset 0 in MSBs, offset k at [LINE_W-1-k*WORD_W -: WORD_W]
- dout  out  NUM_CORES*WORD_W  per-core delivered word, held until that core's next delivery
- dvalid  out  NUM_CORES  per-core one-cycle delivery pulse
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DELIVER.
- IDLE: if any mr high, select the lead core with the round-robin arbiter: first requester at or after rr_ptr, wrapping modulo NUM_CORES. Register the lead line address. Register serve_mask = all cores with mr high whose line address equals the lead's. Go to ISSUE. Otherwise stay.
- ISSUE: mem_read=1, mem_addr=latched line; load wait counter with MEM_LAT; go to WAIT.
- WAIT: decrement the counter. On the last WAIT cycle (counter==1), capture mem_data into the line register; go to DELIVER.
- DELIVER: for each core in serve_mask, dout_i = word at offset maddr_i[OFF_W-1:0] (offset latched in IDLE); dvalid_i=1. rr_ptr = (lead+1) mod NUM_CORES. Go to IDLE.
- Requests raised or changed after the IDLE decision join a later transaction, never the current one.
- Cores must hold mr/maddr stable until their dvalid, and drop or change them the cycle after it. An mr still high in IDLE is a new request.
- Multiple cores on the same line and different offsets are served by one memory read. Cores on the same word each get a copy.
- Reset values: state IDLE, rr_ptr 0, mem_read 0, mem_addr 0, dout all 0, dvalid 0, busy 0, serve_mask 0.

## Timing
- Request seen in IDLE at cycle 0 → mem_read in cycle 1 → mem_data sampled in cycle 1+MEM_LAT → dvalid in cycle 2+MEM_LAT. Latency is 3 cycles for the default configuration.
- Back-to-back transactions occupy 3+MEM_LAT cycles each (IDLE decision cycle included).
- mem_read is never high in two consecutive cycles.
- dvalid and dout update on the same edge. dout is stable while dvalid is low.
- rst_n low at any edge returns to the reset values at that edge. The in-flight transaction is dropped: no dvalid, and late mem_data is ignored.
- MEM_LAT wrap: the counter width is clog2(MEM_LAT+1). No WAIT-skip path exists.

## Structure
- Package dl_ctrl_pkg: state enum (IDLE/ISSUE/WAIT/DELIVER), function computing OFF_W/LADDR_W, and a line-word extract function (MSB-first offset).
- Sub-module dl_rr_arbiter: NUM_CORES-wide rotating-priority find-first. Inputs are the request vector and pointer; outputs are the one-hot grant and the grant index. It is purely combinational; the pointer register lives in dl_ctrl_arb.

## Test plan
- All four cores mr=1, maddr 0,0,1,1; mem_data={1,5,9,13} → one mem_read with mem_addr=0; dvalid=4'b1111 in cycle 3; dout=1,1,5,5.
- Cores 0–3 on lines 1,2,3,4 (offset 0, mem_data model returns line index in word 0) → four mem_reads in order 1,2,3,4, spaced 4 cycles apart; each core's dvalid is alone, and its dout equals its line index.
- Fairness: after core 1 is served (rr_ptr=2), cores 0 and 3 request lines 5 and 6 → mem_addr 6 (core 3) first, then 5.
- Late joiner: core 0 requests line 7; core 2 raises mr for line 7 during WAIT → first dvalid=4'b0001; a second transaction serves core 2 alone.
- Reset mid-WAIT: rst_n low for one cycle → next cycle busy=0, mem_read=0, dvalid stays 0, dout=0; after release, a pending mr is served normally with rr_ptr=0.
- MEM_LAT=3 build: single request → mem_read in cycle 1, dvalid in cycle 5, correct word selected for offsets 0..3.
